sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port accelerator SRAM (1-cycle read latency) between two masters:
  - the host path driven by the ICB slave's sram_wr_*/sram_rd_* ports;
  - the compute engine's request/grant port.
- The host path has no backpressure, so the host always wins.
- The engine is granted only in host-idle cycles.
- Returns read data to the correct owner and keeps conflict/starvation statistics for the status register.

Parameters:
AW, 13, SRAM word-address width
DW, 32, data width
RD_LAT, 1, SRAM read latency in cycles (1..4)
STARVE_MAX, 8'd255, consecutive denied engine-request cycles before starve_flag sets

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
host_wr_en  in  1  host write strobe (single-cycle)
host_wr_addr  in  AW  host write address
host_wr_data  in  DW  host write data
host_rd_en  in  1  host read strobe (single-cycle)
host_rd_addr  in  AW  host read address
host_rd_data  out  DW  host read data, valid RD_LAT cycles after host_rd_en
eng_req  in  1  engine access request, held until granted
eng_we  in  1  engine write (1) / read (0)
eng_addr  in  AW  engine address
eng_wdata  in  DW  engine write data
eng_gnt  out  1  engine access accepted this cycle (combinational)
eng_rvalid  out  1  engine read data valid
eng_rdata  out  DW  engine read data
mem_en  out  1  SRAM enable
mem_we  out  1  SRAM write enable
mem_addr  out  AW  SRAM address
mem_wdata  out  DW  SRAM write data
mem_rdata  in  DW  SRAM read data
stat_clr  in  1  clears counters and sticky flags (pulse)
starve_flag  out  1  sticky: engine denied STARVE_MAX consecutive cycles
coll_flag  out  1  sticky: host_wr_en and host_rd_en asserted together
conflict_cnt  out  16  cycles where eng_req was denied by host activity, wraps
eng_busy  out  1  engine read outstanding in return pipeline

Behaviour:
Reset values:
- Every registered output and internal register is 0: starve_flag, coll_flag, conflict_cnt, eng_rvalid, tag pipeline, starve counter.

Grant logic (combinational, zero latency; the host path timing forbids registering it):
- host_act = host_wr_en | host_rd_en.
- eng_gnt = eng_req & ~host_act.
- Priority for the SRAM port: host write > host read > engine.
- mem_en = host_act | eng_gnt.
- mem_we = host_wr_en | (eng_gnt & eng_we).
- mem_addr and mem_wdata come from the winning source; they are 0 when idle.

Host write/read collision:
- If host_wr_en and host_rd_en are asserted together, the write executes and the read is dropped.
- coll_flag sets; host_rd_data for that read is 0.

Return path:
- An RD_LAT-deep shift register carries a 2-bit owner tag per cycle: NONE=0, HOST=1, ENG=2.
- A tag is pushed each cycle: HOST if a host read executed, ENG if an engine read was granted, else NONE.
- At the pipeline head:
  - HOST tag: host_rd_data = mem_rdata.
  - ENG tag: eng_rvalid = 1 and eng_rdata = mem_rdata.
  - Otherwise the corresponding data output is 0.
- eng_rvalid and eng_rdata are combinational from the head tag and mem_rdata.
- Writes push NONE.
- eng_busy = any ENG tag in the pipeline.

Engine starvation:
- An 8-bit counter increments (saturating) each cycle with eng_req & host_act.
- It clears on any eng_gnt or when eng_req is low.
- When the counter reaches STARVE_MAX, starve_flag sets and stays set until stat_clr.

Conflict counter:
- conflict_cnt increments on every eng_req & host_act cycle and wraps at 16'hFFFF→0.

stat_clr:
- Clears conflict_cnt, the starve counter, starve_flag and coll_flag.
- If stat_clr coincides with an increment or flag set, the clear wins.

Engine request timing:
- The engine may change addr/we/wdata only after eng_gnt.
- Back-to-back engine grants are permitted every cycle.

Reset mid-operation:
- In-flight tags are discarded; no eng_rvalid follows reset.

Decomposition:
- Shared package: owner tag typedef (OWN_NONE/OWN_HOST/OWN_ENG), AW/DW defaults, and the stat bit positions for starve_flag/coll_flag in STAT_REG_RD.
- One sub-module: rd_tag_pipe (parameterised RD_LAT shift register of owner tags, with reset).

Test Plan:
- Engine read at addr 0x010 with host idle → eng_gnt same cycle, mem_addr=0x010; eng_rvalid=1 one cycle later with mem_rdata value (e.g. 0xDEADBEEF).
- Host write 0x0A5 ← 0x12345678 while eng_req is held → eng_gnt=0 and mem_we=1 with host address/data. The next idle cycle grants the engine; conflict_cnt=1.
- Alternating host read at 0x020 and engine read at 0x030 on consecutive cycles → host_rd_data and eng_rdata each return their own word. There is no cross-delivery; eng_busy is high only while the ENG tag is in flight.
- Host active continuously for 300 cycles with eng_req held → starve_flag sets on cycle 255 and conflict_cnt=300. stat_clr → both return to 0.
- host_wr_en and host_rd_en in the same cycle → only the write reaches the SRAM, coll_flag=1, no host read data returned.
- Assert rst_n low for one cycle while an engine read is outstanding → no eng_rvalid afterwards, and all status outputs are 0.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and defaults for the accelerator SRAM port arbiter.
// Owner tags identify who receives read data coming back from the SRAM.
package sram_port_arbiter_pkg;

    localparam int AW_DEF     = 13;
    localparam int DW_DEF     = 32;
    localparam int RD_LAT_DEF = 1;
    localparam logic [7:0] STARVE_MAX_DEF = 8'd255;

    // Bit positions of the sticky flags inside STAT_REG_RD
    localparam int STAT_STARVE_BIT = 0;
    localparam int STAT_COLL_BIT   = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_ENG  = 2'd2
    } own_t;

    function automatic own_t rd_owner(input logic host_rd_exec, input logic eng_rd_gnt);
        own_t o;
        o = OWN_NONE;
        if (host_rd_exec) begin
            o = OWN_HOST;
        end else if (eng_rd_gnt) begin
            o = OWN_ENG;
        end
        return o;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Host, engine and SRAM-side signals of the arbiter; slave = arbiter view.
// Host strobes have no backpressure; the engine holds eng_req until eng_gnt.
interface sram_port_arbiter_if #(
    parameter int AW = sram_port_arbiter_pkg::AW_DEF,
    parameter int DW = sram_port_arbiter_pkg::DW_DEF
);
    logic          host_wr_en;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_rd_en;
    logic [AW-1:0] host_rd_addr;
    logic [DW-1:0] host_rd_data;

    logic          eng_req;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [DW-1:0] eng_wdata;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  host_wr_en, host_wr_addr, host_wr_data,
        input  host_rd_en, host_rd_addr,
        output host_rd_data,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output eng_gnt, eng_rvalid, eng_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output host_wr_en, host_wr_addr, host_wr_data,
        output host_rd_en, host_rd_addr,
        input  host_rd_data,
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  eng_gnt, eng_rvalid, eng_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/sram_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read owner tags; head lines up with mem_rdata.
// One push per cycle, no backpressure; reset discards every in-flight tag.
module sram_port_arbiter_rd_tag_pipe
    import sram_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  own_t push_i,
    output own_t head_o,
    output logic eng_busy_o
);

    own_t stage_q [RD_LAT];
    own_t stage_d [RD_LAT];

    always_comb begin
        stage_d[0] = push_i;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign head_o = stage_q[RD_LAT-1];

    always_comb begin
        eng_busy_o = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (stage_q[i] == OWN_ENG) begin
                eng_busy_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the host path (always wins) and the engine.
// Grant is zero-latency combinational; read data returns RD_LAT cycles later.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int         AW         = AW_DEF,
    parameter int         DW         = DW_DEF,
    parameter int         RD_LAT     = RD_LAT_DEF,
    parameter logic [7:0] STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_port_arbiter_if.slave  bus,
    input  logic                stat_clr,
    output logic                starve_flag,
    output logic                coll_flag,
    output logic [15:0]         conflict_cnt,
    output logic                eng_busy
);

    logic          host_act;
    logic          host_rd_exec;
    logic          eng_gnt_c;
    logic          eng_rd_gnt;
    logic          deny;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    own_t          push_tag;
    own_t          head_tag;

    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic          starve_flag_q, starve_flag_d;
    logic          coll_flag_q, coll_flag_d;
    logic [15:0]   conflict_cnt_q, conflict_cnt_d;

    // A read colliding with a write is dropped, so it never earns a HOST tag
    assign host_act     = bus.host_wr_en | bus.host_rd_en;
    assign host_rd_exec = bus.host_rd_en & ~bus.host_wr_en;
    assign eng_gnt_c    = bus.eng_req & ~host_act;
    assign eng_rd_gnt   = eng_gnt_c & ~bus.eng_we;
    assign deny         = bus.eng_req & host_act;

    always_comb begin
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (bus.host_wr_en) begin
            mem_addr_c  = bus.host_wr_addr;
            mem_wdata_c = bus.host_wr_data;
        end else if (bus.host_rd_en) begin
            mem_addr_c  = bus.host_rd_addr;
        end else if (eng_gnt_c) begin
            mem_addr_c  = bus.eng_addr;
            mem_wdata_c = bus.eng_wdata;
        end
    end

    assign bus.eng_gnt   = eng_gnt_c;
    assign bus.mem_en    = host_act | eng_gnt_c;
    assign bus.mem_we    = bus.host_wr_en | (eng_gnt_c & bus.eng_we);
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;

    assign push_tag = rd_owner(host_rd_exec, eng_rd_gnt);

    sram_port_arbiter_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push_tag),
        .head_o     (head_tag),
        .eng_busy_o (eng_busy)
    );

    assign bus.host_rd_data = (head_tag == OWN_HOST) ? bus.mem_rdata : '0;
    assign bus.eng_rvalid   = (head_tag == OWN_ENG);
    assign bus.eng_rdata    = (head_tag == OWN_ENG) ? bus.mem_rdata : '0;

    // stat_clr overrides every increment and flag set in the same cycle
    always_comb begin
        starve_cnt_d   = starve_cnt_q;
        starve_flag_d  = starve_flag_q;
        coll_flag_d    = coll_flag_q;
        conflict_cnt_d = conflict_cnt_q;
        if (stat_clr) begin
            starve_cnt_d   = '0;
            starve_flag_d  = 1'b0;
            coll_flag_d    = 1'b0;
            conflict_cnt_d = '0;
        end else begin
            if (deny) begin
                starve_cnt_d   = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;
                conflict_cnt_d = conflict_cnt_q + 16'd1;
                if (starve_cnt_d >= STARVE_MAX) begin
                    starve_flag_d = 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
            end
            if (bus.host_wr_en & bus.host_rd_en) begin
                coll_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q   <= '0;
            starve_flag_q  <= 1'b0;
            coll_flag_q    <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            starve_flag_q  <= starve_flag_d;
            coll_flag_q    <= coll_flag_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign starve_flag  = starve_flag_q;
    assign coll_flag    = coll_flag_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed table, hand sequences and random traffic
// checked against a transaction-level model with its own shadow memory.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int RD_LAT = 1;
    localparam logic [7:0] STARVE_MAX = 8'd255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat_clr;
    logic        starve_flag, coll_flag, eng_busy;
    logic [15:0] conflict_cnt;

    sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    sram_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .stat_clr     (stat_clr),
        .starve_flag  (starve_flag),
        .coll_flag    (coll_flag),
        .conflict_cnt (conflict_cnt),
        .eng_busy     (eng_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int a);
        logic [31:0] v;
        v = 32'(a);
        return {16'hA5A5, 3'b000, v[12:0]};
    endfunction

    // SRAM environment: acts on whatever the DUT drives
    logic [DW-1:0] sram [int];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[int'(bus.mem_addr)] = bus.mem_wdata;
            else bus.mem_rdata <= sram.exists(int'(bus.mem_addr)) ? sram[int'(bus.mem_addr)]
                                                                  : pat(int'(bus.mem_addr));
        end
    end

    // Reference model: transactions, shadow memory, plain counters
    typedef struct { own_t own; logic [DW-1:0] data; } ret_t;
    ret_t          pend_q[$];
    logic [DW-1:0] shadow [int];
    int            deny_run, m_conf;
    bit            m_starve, m_coll, last_gnt;
    int            n_chk = 0, n_fail = 0;

    function automatic logic [DW-1:0] shadow_rd(input int a);
        return shadow.exists(a) ? shadow[a] : pat(a);
    endfunction

    task automatic model_reset();
        ret_t r;
        r.own = OWN_NONE; r.data = '0;
        pend_q.delete();
        for (int i = 0; i < RD_LAT; i++) pend_q.push_back(r);
        deny_run = 0; m_conf = 0; m_starve = 0; m_coll = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.host_wr_en = 0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
        bus.host_rd_en = 0; bus.host_rd_addr = '0;
        bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_wdata = '0;
        stat_clr = 0;
    endtask

    // Compare every output at the falling edge against the model
    task automatic half();
        logic ha, g;
        logic [31:0] e_addr, e_wd;
        bit busy;
        #4;
        ha = bus.host_wr_en | bus.host_rd_en;
        g  = bus.eng_req & ~ha;
        e_addr = bus.host_wr_en ? 32'(bus.host_wr_addr) : bus.host_rd_en ? 32'(bus.host_rd_addr)
               : g ? 32'(bus.eng_addr) : 32'd0;
        e_wd   = bus.host_wr_en ? bus.host_wr_data : g ? bus.eng_wdata : 32'd0;
        busy = 0;
        foreach (pend_q[i]) if (pend_q[i].own == OWN_ENG) busy = 1;
        check("eng_gnt",      32'(bus.eng_gnt), 32'(g));
        check("mem_en",       32'(bus.mem_en), 32'(ha | g));
        check("mem_we",       32'(bus.mem_we), 32'(bus.host_wr_en | (g & bus.eng_we)));
        check("mem_addr",     32'(bus.mem_addr), e_addr);
        check("mem_wdata",    bus.mem_wdata, e_wd);
        check("host_rd_data", bus.host_rd_data, pend_q[0].own == OWN_HOST ? pend_q[0].data : 32'd0);
        check("eng_rvalid",   32'(bus.eng_rvalid), 32'(pend_q[0].own == OWN_ENG));
        check("eng_rdata",    bus.eng_rdata, pend_q[0].own == OWN_ENG ? pend_q[0].data : 32'd0);
        check("eng_busy",     32'(eng_busy), 32'(busy));
        check("starve_flag",  32'(starve_flag), 32'(m_starve));
        check("coll_flag",    32'(coll_flag), 32'(m_coll));
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        last_gnt = g;
    endtask

    task automatic edge_upd();
        logic wr, rd, g;
        ret_t r;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        wr = bus.host_wr_en; rd = bus.host_rd_en;
        g  = bus.eng_req & ~(wr | rd);
        r.own = OWN_NONE; r.data = '0;
        if (rd && !wr) begin
            r.own = OWN_HOST; r.data = shadow_rd(int'(bus.host_rd_addr));
        end else if (g && !bus.eng_we) begin
            r.own = OWN_ENG; r.data = shadow_rd(int'(bus.eng_addr));
        end
        if (wr) shadow[int'(bus.host_wr_addr)] = bus.host_wr_data;
        else if (g && bus.eng_we) shadow[int'(bus.eng_addr)] = bus.eng_wdata;
        void'(pend_q.pop_front());
        pend_q.push_back(r);
        if (stat_clr) begin
            deny_run = 0; m_conf = 0; m_starve = 0; m_coll = 0;
        end else begin
            if (bus.eng_req && (wr || rd)) begin
                deny_run++;
                m_conf = (m_conf + 1) % 65536;
                if (deny_run >= int'(STARVE_MAX)) m_starve = 1;
            end else begin
                deny_run = 0;
            end
            if (wr && rd) m_coll = 1;
        end
    endtask

    task automatic cycle();
        half();
        edge_upd();
    endtask

    task automatic clr_cycle();
        idle(); stat_clr = 1; cycle(); stat_clr = 0;
    endtask

    typedef struct {
        logic wr, rd, req, we;
        logic exp_gnt, exp_en, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit req_act;
        logic rwe;
        logic [AW-1:0] raddr;
        logic [DW-1:0] rwd;
        int k;

        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 13'h000, 32'h0000_0000};
        vecs[1] = '{0, 0, 1, 0, 1, 1, 0, 13'h030, 32'hCAFE_F00D};
        vecs[2] = '{0, 0, 1, 1, 1, 1, 1, 13'h030, 32'hCAFE_F00D};
        vecs[3] = '{1, 0, 1, 1, 0, 1, 1, 13'h0A5, 32'h1234_5678};
        vecs[4] = '{0, 1, 1, 0, 0, 1, 0, 13'h020, 32'h0000_0000};
        vecs[5] = '{1, 1, 1, 0, 0, 1, 1, 13'h0A5, 32'h1234_5678};
        vecs[6] = '{0, 1, 0, 0, 0, 1, 0, 13'h020, 32'h0000_0000};
        vecs[7] = '{1, 0, 0, 0, 0, 1, 1, 13'h0A5, 32'h1234_5678};

        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst starve_flag",  32'(starve_flag), 32'd0);
        check("rst coll_flag",    32'(coll_flag), 32'd0);
        check("rst conflict_cnt", 32'(conflict_cnt), 32'd0);
        check("rst eng_rvalid",   32'(bus.eng_rvalid), 32'd0);
        check("rst eng_busy",     32'(eng_busy), 32'd0);
        rst_n = 1;

        foreach (vecs[i]) begin
            bus.host_wr_en = vecs[i].wr; bus.host_wr_addr = 13'h0A5; bus.host_wr_data = 32'h1234_5678;
            bus.host_rd_en = vecs[i].rd; bus.host_rd_addr = 13'h020;
            bus.eng_req = vecs[i].req; bus.eng_we = vecs[i].we;
            bus.eng_addr = 13'h030; bus.eng_wdata = 32'hCAFE_F00D;
            half();
            check("vec gnt",   32'(bus.eng_gnt), 32'(vecs[i].exp_gnt));
            check("vec en",    32'(bus.mem_en), 32'(vecs[i].exp_en));
            check("vec we",    32'(bus.mem_we), 32'(vecs[i].exp_we));
            check("vec addr",  32'(bus.mem_addr), 32'(vecs[i].exp_addr));
            check("vec wdata", bus.mem_wdata, vecs[i].exp_wdata);
            edge_upd();
        end

        // Engine write then read of 0x010 with the host idle
        clr_cycle();
        bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 13'h010; bus.eng_wdata = 32'hDEAD_BEEF;
        cycle();
        bus.eng_we = 0;
        half();
        check("seq1 gnt", 32'(bus.eng_gnt), 32'd1);
        check("seq1 addr", 32'(bus.mem_addr), 32'h010);
        edge_upd();
        idle();
        half();
        check("seq1 rvalid", 32'(bus.eng_rvalid), 32'd1);
        check("seq1 rdata", bus.eng_rdata, 32'hDEAD_BEEF);
        check("seq1 busy", 32'(eng_busy), 32'd1);
        edge_upd();
        half();
        check("seq1 busy after", 32'(eng_busy), 32'd0);
        edge_upd();

        // Host write wins over a held engine request
        bus.host_wr_en = 1; bus.host_wr_addr = 13'h0A5; bus.host_wr_data = 32'h1234_5678;
        bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 13'h040;
        half();
        check("seq2 gnt", 32'(bus.eng_gnt), 32'd0);
        check("seq2 we", 32'(bus.mem_we), 32'd1);
        check("seq2 addr", 32'(bus.mem_addr), 32'h0A5);
        check("seq2 wdata", bus.mem_wdata, 32'h1234_5678);
        edge_upd();
        bus.host_wr_en = 0;
        half();
        check("seq2 late gnt", 32'(bus.eng_gnt), 32'd1);
        edge_upd();
        check("seq2 conflict_cnt", 32'(conflict_cnt), 32'd1);
        idle();
        cycle();

        // Alternating host and engine reads keep their own data
        bus.host_wr_en = 1; bus.host_wr_addr = 13'h020; bus.host_wr_data = 32'h1111_2222; cycle();
        bus.host_wr_addr = 13'h030; bus.host_wr_data = 32'h3333_4444; cycle();
        idle();
        bus.host_rd_en = 1; bus.host_rd_addr = 13'h020;
        cycle();
        idle();
        bus.eng_req = 1; bus.eng_addr = 13'h030;
        half();
        check("seq3 host data", bus.host_rd_data, 32'h1111_2222);
        check("seq3 no eng", 32'(bus.eng_rvalid), 32'd0);
        check("seq3 busy pre", 32'(eng_busy), 32'd0);
        edge_upd();
        idle();
        half();
        check("seq3 eng data", bus.eng_rdata, 32'h3333_4444);
        check("seq3 host zero", bus.host_rd_data, 32'd0);
        check("seq3 busy", 32'(eng_busy), 32'd1);
        edge_upd();

        // 300 denied cycles: starvation at 255, conflict count 300, clear wins
        clr_cycle();
        bus.host_rd_en = 1; bus.host_rd_addr = 13'h020;
        bus.eng_req = 1; bus.eng_addr = 13'h050;
        repeat (254) cycle();
        check("seq4 starve@254", 32'(starve_flag), 32'd0);
        cycle();
        check("seq4 starve@255", 32'(starve_flag), 32'd1);
        repeat (45) cycle();
        check("seq4 conflict300", 32'(conflict_cnt), 32'd300);
        stat_clr = 1;
        cycle();
        stat_clr = 0;
        check("seq4 clr conflict", 32'(conflict_cnt), 32'd0);
        check("seq4 clr starve", 32'(starve_flag), 32'd0);
        idle();
        cycle();

        // Simultaneous host write and read
        bus.host_wr_en = 1; bus.host_wr_addr = 13'h060; bus.host_wr_data = 32'h7777_8888;
        bus.host_rd_en = 1; bus.host_rd_addr = 13'h061;
        half();
        check("seq5 we", 32'(bus.mem_we), 32'd1);
        check("seq5 addr", 32'(bus.mem_addr), 32'h060);
        edge_upd();
        idle();
        half();
        check("seq5 no rd data", bus.host_rd_data, 32'd0);
        check("seq5 coll", 32'(coll_flag), 32'd1);
        edge_upd();

        // Reset while an engine read is in flight
        bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 13'h030;
        cycle();
        idle();
        rst_n = 0;
        model_reset();
        half();
        check("seq6 rvalid", 32'(bus.eng_rvalid), 32'd0);
        check("seq6 busy", 32'(eng_busy), 32'd0);
        check("seq6 coll", 32'(coll_flag), 32'd0);
        check("seq6 conflict", 32'(conflict_cnt), 32'd0);
        edge_upd();
        rst_n = 1;
        cycle();

        // Random traffic with periodic long host bursts
        req_act = 0; rwe = 0; raddr = '0; rwd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!req_act && $urandom_range(0, 9) < 6) begin
                req_act = 1;
                rwe   = 1'($urandom_range(0, 1));
                raddr = 13'($urandom_range(0, 63));
                rwd   = $urandom;
            end
            idle();
            bus.eng_req = req_act; bus.eng_we = rwe; bus.eng_addr = raddr; bus.eng_wdata = rwd;
            bus.host_wr_addr = 13'($urandom_range(0, 63));
            bus.host_wr_data = $urandom;
            bus.host_rd_addr = 13'($urandom_range(0, 63));
            k = $urandom_range(0, 19);
            if ((i % 1000) >= 500 && (i % 1000) < 800) k = 6;
            bus.host_wr_en = (k < 5) || (k == 10);
            bus.host_rd_en = (k >= 5 && k < 10) || (k == 10);
            stat_clr = ($urandom_range(0, 99) == 0);
            cycle();
            if (last_gnt) req_act = 0;
        end
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
